// File: rtl/stream_pkg.sv
// Shared definitions for the stream arbitration blocks.
//   MODE_SEL / MODE_RR : arbitration mode encodings for stream_arb_mux.MODE
//   arb_state_e        : packet-lock state of the arbiter
//   clog2()            : ceiling log2, usable in parameter expressions
package stream_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker.
//   req   : one request bit per channel
//   ptr   : highest-priority channel index (must be < CH_NUM)
//   grant : one-hot grant of the first requester at or above ptr,
//           searching upward with wrap; all zero when nothing requests
module rr_arbiter #(
    parameter int CH_NUM = 4,
    parameter int SEL_WD = 2
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [SEL_WD-1:0] ptr,
    output logic [CH_NUM-1:0] grant
);

    logic [2*CH_NUM-1:0] req_dbl;
    logic [CH_NUM-1:0]   req_rot;
    logic [CH_NUM-1:0]   grant_rot;
    logic [2*CH_NUM-1:0] grant_dbl;

    // Rotate so that channel ptr lands on bit 0, take the lowest set bit,
    // then rotate the one-hot result back. Duplicating the vector turns
    // the rotations into plain shifts.
    assign req_dbl   = {req, req} >> ptr;
    assign req_rot   = req_dbl[CH_NUM-1:0];
    assign grant_rot = req_rot & (~req_rot + CH_NUM'(1));
    assign grant_dbl = {grant_rot, grant_rot} << ptr;
    assign grant     = grant_dbl[2*CH_NUM-1:CH_NUM];

endmodule

// File: rtl/stream_arb_mux.sv
// Packet-aware N:1 stream multiplexer with a single registered output slot.
//   clk, rstn        : clock, asynchronous active-low reset
//   sel              : channel select (MODE_SEL only)
//   s_data/s_valid/s_last/s_ready : CH_NUM input streams, channel k payload
//                      at s_data[k*DATA_WD +: DATA_WD]
//   m_data/m_id/m_last/m_valid/m_ready : output stream, m_id = source channel
// A beat with s_last=0 locks the grant to its channel until the closing
// beat with s_last=1 has been taken, so packets never interleave.
module stream_arb_mux
    import stream_pkg::*;
#(
    parameter  int DATA_WD = 4,
    parameter  int CH_NUM  = 4,
    parameter  int MODE    = 1,
    localparam int SEL_WD  = (CH_NUM > 1) ? clog2(CH_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [SEL_WD-1:0]         sel,
    input  logic [CH_NUM*DATA_WD-1:0] s_data,
    input  logic [CH_NUM-1:0]         s_valid,
    input  logic [CH_NUM-1:0]         s_last,
    output logic [CH_NUM-1:0]         s_ready,
    output logic [DATA_WD-1:0]        m_data,
    output logic [SEL_WD-1:0]         m_id,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready
);

    arb_state_e          state_reg,   state_next;
    logic [SEL_WD-1:0]   lock_ch_reg, lock_ch_next;
    logic [SEL_WD-1:0]   ptr_reg,     ptr_next;
    logic                m_valid_reg, m_valid_next;
    logic [DATA_WD-1:0]  m_data_reg,  m_data_next;
    logic [SEL_WD-1:0]   m_id_reg,    m_id_next;
    logic                m_last_reg,  m_last_next;

    logic                load_ok;
    logic [CH_NUM-1:0]   lock_gnt;
    logic [CH_NUM-1:0]   sel_gnt;
    logic [CH_NUM-1:0]   rr_gnt;
    logic [CH_NUM-1:0]   grant;
    logic [SEL_WD-1:0]   grant_id;
    logic [DATA_WD-1:0]  grant_data;
    logic                grant_last;
    logic                xfer;
    logic [DATA_WD-1:0]  data_masked [CH_NUM];

    // The slot can take a new beat when it is empty or being drained.
    assign load_ok = !m_valid_reg || m_ready;

    // Per-channel decode of the locked channel and of sel; an out-of-range
    // sel matches no channel, which yields an empty grant.
    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            assign lock_gnt[gi]    = (lock_ch_reg == SEL_WD'(gi));
            assign sel_gnt[gi]     = (sel == SEL_WD'(gi));
            assign data_masked[gi] = grant[gi] ? s_data[gi*DATA_WD +: DATA_WD] : '0;
        end
    endgenerate

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(
                .CH_NUM (CH_NUM),
                .SEL_WD (SEL_WD)
            ) u_rr_arbiter (
                .req   (s_valid),
                .ptr   (ptr_reg),
                .grant (rr_gnt)
            );
        end else begin : g_no_rr
            assign rr_gnt = '0;
        end
    endgenerate

    // A held lock overrides both arbitration modes, even when the locked
    // channel has dropped s_valid.
    always_comb begin
        grant = rr_gnt;
        if (state_reg == ARB_LOCKED) begin
            grant = lock_gnt;
        end else if (MODE == MODE_SEL) begin
            grant = sel_gnt;
        end
    end

    always_comb begin
        grant_id   = '0;
        grant_data = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (grant[k]) begin
                grant_id = grant_id | SEL_WD'(k);
            end
            grant_data = grant_data | data_masked[k];
        end
    end

    assign grant_last = |(grant & s_last);
    assign s_ready    = rstn ? (grant & {CH_NUM{load_ok}}) : '0;
    assign xfer       = |(s_ready & s_valid);

    always_comb begin
        state_next   = state_reg;
        lock_ch_next = lock_ch_reg;
        ptr_next     = ptr_reg;
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        m_id_next    = m_id_reg;
        m_last_next  = m_last_reg;
        if (xfer) begin
            m_valid_next = 1'b1;
            m_data_next  = grant_data;
            m_id_next    = grant_id;
            m_last_next  = grant_last;
            lock_ch_next = grant_id;
            state_next   = grant_last ? ARB_OPEN : ARB_LOCKED;
            // Priority moves past a channel only when its packet closes.
            if (grant_last) begin
                ptr_next = (grant_id == SEL_WD'(CH_NUM - 1)) ? '0 : grant_id + SEL_WD'(1);
            end
        end else if (m_ready) begin
            m_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= ARB_OPEN;
            lock_ch_reg <= '0;
            ptr_reg     <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_id_reg    <= '0;
            m_last_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lock_ch_reg <= lock_ch_next;
            ptr_reg     <= ptr_next;
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
            m_id_reg    <= m_id_next;
            m_last_reg  <= m_last_next;
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_id    = m_id_reg;
    assign m_last  = m_last_reg;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: instance 0 is round-robin with 4 channels,
// instance 1 is external-select with 3 channels. A reference model predicts
// grants and queues expected output beats; a monitor checks DUT output
// against the queue heads.
module tb_stream_arb_mux;

    typedef struct {
        int ch;
        int data;
        int last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] s_data_a  [2];
    logic [3:0]  s_valid_a [2];
    logic [3:0]  s_last_a  [2];
    logic        m_ready_a [2];
    logic [1:0]  sel_a     [2];

    logic [3:0]  s_ready0;
    logic [2:0]  s_ready1;
    logic [3:0]  m_data0,  m_data1;
    logic [1:0]  m_id0,    m_id1;
    logic        m_last0,  m_last1;
    logic        m_valid0, m_valid1;

    int total = 0;
    int bad   = 0;

    beat_t q0[$];
    beat_t q1[$];

    int mv      [2];
    int lock    [2];
    int lock_ch [2];
    int ptr     [2];

    always #5 clk = ~clk;

    stream_arb_mux #(.DATA_WD(4), .CH_NUM(4), .MODE(1)) u_rr (
        .clk     (clk),
        .rstn    (rstn),
        .sel     (sel_a[0]),
        .s_data  (s_data_a[0]),
        .s_valid (s_valid_a[0]),
        .s_last  (s_last_a[0]),
        .s_ready (s_ready0),
        .m_data  (m_data0),
        .m_id    (m_id0),
        .m_last  (m_last0),
        .m_valid (m_valid0),
        .m_ready (m_ready_a[0])
    );

    stream_arb_mux #(.DATA_WD(4), .CH_NUM(3), .MODE(0)) u_sel (
        .clk     (clk),
        .rstn    (rstn),
        .sel     (sel_a[1]),
        .s_data  (s_data_a[1][11:0]),
        .s_valid (s_valid_a[1][2:0]),
        .s_last  (s_last_a[1][2:0]),
        .s_ready (s_ready1),
        .m_data  (m_data1),
        .m_id    (m_id1),
        .m_last  (m_last1),
        .m_valid (m_valid1),
        .m_ready (m_ready_a[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grant is derived from the arbitration rules
    // (lock, select or first valid at/after the priority pointer).
    int    chn, g, er, ar, av, load, c;
    beat_t nb;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chn = (i == 0) ? 4 : 3;
            ar  = (i == 0) ? int'(s_ready0) : int'(s_ready1);
            av  = (i == 0) ? int'(m_valid0) : int'(m_valid1);
            if (!rstn) begin
                chk($sformatf("u%0d rst s_ready", i), ar, 0);
                chk($sformatf("u%0d rst m_valid", i), av, 0);
                mv[i] = 0; lock[i] = 0; lock_ch[i] = 0; ptr[i] = 0;
                if (i == 0) q0.delete(); else q1.delete();
            end else begin
                chk($sformatf("u%0d m_valid", i), av, mv[i]);
                load = (mv[i] == 0 || m_ready_a[i]) ? 1 : 0;
                g = -1;
                if (lock[i] != 0) begin
                    g = lock_ch[i];
                end else if (i == 1) begin
                    if (int'(sel_a[1]) < chn) g = int'(sel_a[1]);
                end else begin
                    for (int k = 0; k < chn; k++) begin
                        c = (ptr[i] + k) % chn;
                        if (g < 0 && s_valid_a[i][c]) g = c;
                    end
                end
                er = (g >= 0 && load != 0) ? (1 << g) : 0;
                chk($sformatf("u%0d s_ready", i), ar, er);
                if (er != 0 && s_valid_a[i][g]) begin
                    nb.ch   = g;
                    nb.data = int'((s_data_a[i] >> (4 * g)) & 16'hF);
                    nb.last = int'(s_last_a[i][g]);
                    if (i == 0) q0.push_back(nb); else q1.push_back(nb);
                    mv[i]      = 1;
                    lock[i]    = (nb.last != 0) ? 0 : 1;
                    lock_ch[i] = g;
                    if (nb.last != 0) ptr[i] = (g + 1) % chn;
                end else if (m_ready_a[i]) begin
                    mv[i] = 0;
                end
            end
        end
    end

    // Monitor: any presented output beat must match the oldest expected beat.
    beat_t hb;
    int    qs;
    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < 2; i++) begin
                av = (i == 0) ? int'(m_valid0) : int'(m_valid1);
                if (av != 0) begin
                    qs = (i == 0) ? q0.size() : q1.size();
                    if (qs == 0) begin
                        total = total + 1;
                        bad   = bad + 1;
                        $display("FAIL u%0d unexpected beat act=valid exp=none t=%0t", i, $time);
                    end else begin
                        hb = (i == 0) ? q0[0] : q1[0];
                        chk($sformatf("u%0d m_id", i),   (i == 0) ? int'(m_id0)   : int'(m_id1),   hb.ch);
                        chk($sformatf("u%0d m_data", i), (i == 0) ? int'(m_data0) : int'(m_data1), hb.data);
                        chk($sformatf("u%0d m_last", i), (i == 0) ? int'(m_last0) : int'(m_last1), hb.last);
                        if (m_ready_a[i]) begin
                            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int beat;
    int guard;

    initial begin
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_data_a[i]  = '0;
            s_valid_a[i] = '0;
            s_last_a[i]  = '0;
            m_ready_a[i] = 1'b1;
            sel_a[i]     = '0;
        end
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Round-robin rotation with every channel sending 1-beat packets.
        s_valid_a[0] = 4'hF; s_last_a[0] = 4'hF; s_data_a[0] = 16'h3210;
        repeat (6) tick();

        // ch1 3-beat packet competing with ch2.
        s_valid_a[0] = 4'b0110;
        beat  = 0;
        guard = 0;
        while (beat < 3 && guard < 20) begin
            s_data_a[0] = {4'h0, 4'hA, 4'(beat + 1), 4'h0};
            s_last_a[0] = {1'b0, 1'b1, (beat == 2), 1'b0};
            @(negedge clk);
            if (s_ready0[1]) beat++;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid_a[0] = 4'b0100;
        repeat (3) tick();

        // Output stall holding a 0x5 beat.
        s_valid_a[0] = 4'hF; s_last_a[0] = 4'hF; s_data_a[0] = 16'h5555;
        tick();
        m_ready_a[0] = 1'b0;
        repeat (5) tick();
        m_ready_a[0] = 1'b1;
        tick();

        // Reset in the middle of a ch2 packet while the output is stalled.
        s_valid_a[0] = 4'b0100; s_last_a[0] = 4'h0; s_data_a[0] = 16'h0C00;
        repeat (2) tick();
        m_ready_a[0] = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        s_valid_a[0] = 4'hF; s_last_a[0] = 4'hF; s_data_a[0] = 16'h7654;
        m_ready_a[0] = 1'b1;
        repeat (4) tick();
        s_valid_a[0] = 4'h0;

        // External select: out-of-range sel, then sel change mid-packet.
        s_valid_a[1] = 4'b0111; s_last_a[1] = 4'b0111; s_data_a[1] = 16'h0987;
        sel_a[1] = 2'd3;
        repeat (4) tick();
        sel_a[1] = 2'd0; s_last_a[1] = 4'b0110;
        repeat (2) tick();
        sel_a[1] = 2'd2;
        repeat (2) tick();
        s_valid_a[1] = 4'b0110;
        tick();
        s_valid_a[1] = 4'b0111;
        s_last_a[1] = 4'b0111;
        repeat (3) tick();

        // Random traffic on both instances.
        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                s_valid_a[i] = 4'($urandom);
                s_last_a[i]  = 4'($urandom) & 4'($urandom);
                s_data_a[i]  = 16'($urandom);
                m_ready_a[i] = ($urandom_range(0, 9) < 7);
            end
            sel_a[1] = 2'($urandom_range(0, 3));
            tick();
        end

        // Drain the output slots.
        for (int i = 0; i < 2; i++) begin
            s_valid_a[i] = '0;
            m_ready_a[i] = 1'b1;
        end
        repeat (4) tick();
        chk("u0 drain", q0.size(), 0);
        chk("u1 drain", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
